led_step_ctrl: RTL
==================

Name: led_step_ctrl

Overview:
- Upstream control stage for the 4-LED chaser.
- Debounces three active-low push keys: run/pause, speed, direction.
- Outputs a one-cycle step strobe at a selectable period, plus a direction bit. The chaser shifts one position per strobe.
- Replaces the chaser's free-running fixed 0.5 s counter with a user-controlled timebase.

Parameters:
- DEBOUNCE_MAX, 20'd999_999: stable-level count for a key (20 ms at 50 MHz).
- BASE_MAX, 25'd24_999_999: terminal count for slowest speed (0.5 s at 50 MHz). BASE_MAX+1 must be divisible by 8.

Ports:
- sys_clk  in  1  system clock, 50 MHz.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- key_run  in  1  raw run/pause key, active-low, asynchronous to sys_clk.
- key_speed  in  1  raw speed-cycle key, active-low, asynchronous.
- key_dir  in  1  raw direction key, active-low, asynchronous.
- step_flag  out  1  one-cycle strobe: advance LED pattern one position.
- dir  out  1  0 = shift left (led0→led3), 1 = shift right.
- running  out  1  1 = stepping enabled.
- speed_sel  out  2  current speed index 0..3.

Behaviour:

Reset:
- Clock is sys_clk; reset is sys_rst_n, asynchronous, active-low.
- Reset values: step_flag=0, dir=0, running=1, speed_sel=0, tick counter=0.
- Sync flops, stable key levels and edge history reset to 1 (released).
- Debounce counters reset to 0.

Input sync:
- Each key passes through a 2-flop synchronizer before debounce.

Debounce, per key, independent:
- If synced level ≠ stable level: counter increments. Otherwise counter clears to 0.
- When counter == DEBOUNCE_MAX with levels still differing: stable ← synced, counter ← 0.
- Press event: one-cycle pulse on a stable 1→0 transition only. Release generates nothing.
- Glitch shorter than DEBOUNCE_MAX+1 cycles: no stable change, no event.
- Latency from raw edge to press event: DEBOUNCE_MAX + 4 cycles (2 sync, DEBOUNCE_MAX+1 count, 1 edge register), ±1 for sampling.

Control registers:
- run event: running toggles.
- dir event: dir toggles. Takes effect on the next strobe; tick counter is not disturbed.
- speed event: speed_sel ← speed_sel+1, wrapping 3→0. Tick counter ← 0.

Tick generation:
- period_max = ((BASE_MAX+1) >> speed_sel) − 1. Speed 0 is slowest; each step doubles the rate.
- Width: 25-bit; the shift is combinational.
- While running=1: counter counts 0..period_max, then wraps to 0.
- step_flag is registered. It is 1 for exactly the cycle after the edge where counter == period_max, with running=1 and no speed/run event on that edge.
- Strobe spacing at constant speed: period_max+1 cycles.
- While running=0: counter holds its value and step_flag stays 0. On resume, counting continues from the held value; there is no strobe burst.

Simultaneous events:
- speed event on the wrap edge: counter ← 0, strobe suppressed.
- run event on the wrap edge: strobe suppressed, running toggles.
- dir event on the wrap edge: strobe is issued; the new dir is visible in the same cycle as step_flag.
- Multiple key events on the same edge are all applied.

Reset mid-operation:
- All state returns to reset values immediately, independent of sys_clk.
- A key held low through reset release does not produce an event. Its stable level is 1, so the debounce then observes a low level and produces one press event after DEBOUNCE_MAX+1 cycles.

Test Plan:
Bench parameters: DEBOUNCE_MAX=4, BASE_MAX=15, giving period_max 15/7/3/1.
1. Reset release, no keys → running=1, speed_sel=0. step_flag pulses one cycle every 16 cycles; first pulse 16 cycles after reset release ±1. dir=0.
2. key_speed low for 20 cycles then high → exactly one event; speed_sel=1; counter cleared. Next strobe 8 cycles after the event, then every 8. Repeat three more times → speed_sel 2 (spacing 4), 3 (spacing 2), then wraps to 0 (spacing 16).
3. key_run pulsed low 3 cycles (glitch, shorter than DEBOUNCE_MAX+1) → no event, running stays 1. Held low 10 cycles → running=0, no strobes for 100 cycles. Second press → running=1; first strobe arrives after the remaining count (held value preserved).
4. key_dir press timed so its event lands on the wrap edge → step_flag=1 with dir=1 in the same cycle. Later strobes keep dir=1.
5. key_speed event forced on the wrap edge → no strobe that cycle; next strobe at the new period_max+1.
6. Assert sys_rst_n low mid-count with running=0, speed_sel=2, dir=1 → outputs immediately 0/0/1/0 (step_flag, dir, running, speed_sel). Hold key_run low across reset release → one press event after DEBOUNCE_MAX+1 cycles; running becomes 0.

Source files
------------

// File: rtl/led_step_ctrl.sv
// Debounced run/speed/direction keys driving a selectable-period step strobe for the LED chaser.
// Key press to control update takes DEBOUNCE_MAX+4 cycles; no backpressure, strobe is a plain pulse.
module led_step_ctrl #(
  parameter logic [19:0] DEBOUNCE_MAX = 20'd999_999,
  parameter logic [24:0] BASE_MAX     = 25'd24_999_999
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       key_run,
  input  logic       key_speed,
  input  logic       key_dir,
  output logic       step_flag,
  output logic       dir,
  output logic       running,
  output logic [1:0] speed_sel
);

  localparam int RUN = 0;
  localparam int SPD = 1;
  localparam int DIR = 2;

  logic [2:0]  key_raw;
  logic [2:0]  sync1;
  logic [2:0]  sync2;
  logic [2:0]  stable;
  logic [2:0]  hist;
  logic [2:0]  press;
  logic [24:0] tick_cnt;
  logic [24:0] base_p1;
  logic [24:0] period_max;
  logic        wrap;

  assign key_raw = {key_dir, key_speed, key_run};

  // Keys are released (high) out of reset so a key held through reset is seen as a fresh press.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      sync1 <= 3'b111;
      sync2 <= 3'b111;
      hist  <= 3'b111;
    end else begin
      sync1 <= key_raw;
      sync2 <= sync1;
      hist  <= stable;
    end
  end

  for (genvar g = 0; g < 3; g++) begin : g_db
    logic [19:0] db_cnt;
    logic        db_stable;

    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
      if (!sys_rst_n) begin
        db_cnt    <= '0;
        db_stable <= 1'b1;
      end else if (sync2[g] != db_stable) begin
        if (db_cnt == DEBOUNCE_MAX) begin
          db_stable <= sync2[g];
          db_cnt    <= '0;
        end else begin
          db_cnt <= db_cnt + 20'd1;
        end
      end else begin
        db_cnt <= '0;
      end
    end

    assign stable[g] = db_stable;
  end

  assign press = hist & ~stable;

  assign base_p1    = BASE_MAX + 25'd1;
  assign period_max = (base_p1 >> speed_sel) - 25'd1;
  assign wrap       = (tick_cnt == period_max);

  // Speed and run events on the wrap edge swallow that strobe; a dir event does not.
  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      tick_cnt  <= '0;
      step_flag <= 1'b0;
      dir       <= 1'b0;
      running   <= 1'b1;
      speed_sel <= 2'd0;
    end else begin
      step_flag <= running && wrap && !press[SPD] && !press[RUN];
      if (press[RUN]) running <= ~running;
      if (press[DIR]) dir <= ~dir;
      if (press[SPD]) begin
        speed_sel <= speed_sel + 2'd1;
        tick_cnt  <= '0;
      end else if (running) begin
        tick_cnt <= wrap ? '0 : tick_cnt + 25'd1;
      end
    end
  end

endmodule
